// File: rtl/main_memory_pkg.sv
// Shared geometry and address-field helpers for the data cache and its
// backing store. Both sides slice addresses through these functions so the
// field boundaries live in exactly one place.
package main_memory_pkg;

   localparam int ADDR_W      = 10;
   localparam int WORD_W      = 32;
   localparam int BLOCK_WORDS = 4;

   localparam int BLOCK_W     = WORD_W * BLOCK_WORDS;        // 128
   localparam int BYTE_OFF_W  = $clog2(WORD_W / 8);          // 2
   localparam int WORD_SEL_W  = $clog2(BLOCK_WORDS);         // 2
   localparam int OFFSET_W    = WORD_SEL_W + BYTE_OFF_W;     // 4
   localparam int BLOCK_NUM_W = ADDR_W - OFFSET_W;           // 6
   localparam int NUM_BLOCKS  = 1 << BLOCK_NUM_W;            // 64
   localparam int WORD_ADDR_W = BLOCK_NUM_W + WORD_SEL_W;    // 8
   localparam int NUM_WORDS   = NUM_BLOCKS * BLOCK_WORDS;    // 256

   // Cache-side split of the block number: 4 lines, so 2 index bits.
   localparam int INDEX_W     = 2;
   localparam int TAG_W       = ADDR_W - OFFSET_W - INDEX_W; // 4

   // Block number: address[9:4].
   function automatic logic [BLOCK_NUM_W-1:0] addr_block(input logic [ADDR_W-1:0] a);
      return BLOCK_NUM_W'(a >> OFFSET_W);
   endfunction

   // Tag: address[9:6].
   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return TAG_W'(a >> (OFFSET_W + INDEX_W));
   endfunction

   // Cache line index: address[5:4].
   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
      return INDEX_W'(a >> OFFSET_W);
   endfunction

   // Word within block: address[3:2].
   function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
      return WORD_SEL_W'(a >> BYTE_OFF_W);
   endfunction

   // Byte within word: address[1:0].
   function automatic logic [BYTE_OFF_W-1:0] addr_byte(input logic [ADDR_W-1:0] a);
      return BYTE_OFF_W'(a);
   endfunction

endpackage

// File: rtl/main_memory_word_array.sv
// 256 x 32 word storage, cleared asynchronously by rst_n. One block is
// exposed at a time: four combinational read ports and one block-wide write
// port share the same block selector.
module mem_word_array
   import main_memory_pkg::*;
(
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  write_en,
   input  logic [BLOCK_NUM_W-1:0]                block_sel,
   input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]    write_words,
   output logic [BLOCK_WORDS-1:0][WORD_W-1:0]    read_words
);

   logic [WORD_W-1:0] mem [NUM_WORDS];

   // Storage: clear everything on reset, otherwise overwrite the whole selected block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (write_en) begin
         for (int k = 0; k < BLOCK_WORDS; k++) begin
            mem[{block_sel, WORD_SEL_W'(k)}] <= write_words[k];
         end
      end
   end

   // Read ports: word k of the block is storage word {block, k}, no write bypass.
   always_comb begin
      read_words = '0;
      for (int k = 0; k < BLOCK_WORDS; k++) begin
         read_words[k] = mem[{block_sel, WORD_SEL_W'(k)}];
      end
   end

endmodule

// File: rtl/main_memory.sv
// Block-granular backing store below the write-through data cache.
// Reads are combinational on the addressed block; writes replace the whole
// block on the rising edge. The low four address bits are ignored.
module main_memory
   import main_memory_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                read_write,
   input  logic [ADDR_W-1:0]   address,
   input  logic [BLOCK_W-1:0]  writeData,
   output logic [BLOCK_W-1:0]  readData
);

   logic [BLOCK_NUM_W-1:0]               block_sel;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0]   write_words;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0]   read_words;

   assign block_sel = addr_block(address);

   // Unpack the incoming block (word 0 in the low 32 bits) and pack the read block the same way.
   always_comb begin
      write_words = '0;
      readData    = '0;
      for (int k = 0; k < BLOCK_WORDS; k++) begin
         write_words[k]                = writeData[k*WORD_W +: WORD_W];
         readData[k*WORD_W +: WORD_W]  = read_words[k];
      end
   end

   mem_word_array u_array (
      .clk         (clk),
      .rst_n       (rst_n),
      .write_en    (read_write),
      .block_sel   (block_sel),
      .write_words (write_words),
      .read_words  (read_words)
   );

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: each task drives one scenario and checks
// readData against hand-computed values.
module tb_main_memory;

   logic         clk;
   logic         rst_n;
   logic         read_write;
   logic [9:0]   address;
   logic [127:0] writeData;
   logic [127:0] readData;

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] ZERO   = 128'h0;
   localparam logic [127:0] PAT_WR = 128'h33333333_22222222_11111111_00000000;
   localparam logic [127:0] PAT_A  = {4{32'hAAAAAAAA}};
   localparam logic [127:0] PAT_5  = {4{32'h55555555}};
   localparam logic [127:0] PAT_F  = {4{32'hFFFFFFFF}};
   localparam logic [127:0] PAT_12 = 128'h1234;
   localparam logic [127:0] PAT_C  = 128'hCAFEF00D_0BADBEEF_DEADC0DE_01234567;

   main_memory dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .read_write (read_write),
      .address    (address),
      .writeData  (writeData),
      .readData   (readData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One write cycle: set up on the falling edge, commit on the rising edge.
   task automatic do_write(input logic [9:0] a, input logic [127:0] d);
      @(negedge clk);
      address    = a;
      writeData  = d;
      read_write = 1'b1;
      @(posedge clk);
      #1;
      read_write = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] addrs [3];
      addrs[0] = 10'h000; addrs[1] = 10'h1F0; addrs[2] = 10'h3F0;
      rst_n      = 1'b0;
      read_write = 1'b1;
      writeData  = PAT_F;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         address = addrs[i];
         #1;
         checks++;
         if (readData !== ZERO) begin
            failures++;
            $display("FAIL reset_read addr=%h got=%h want=%h", addrs[i], readData, ZERO);
         end
         // A write edge while in reset must be dropped.
         @(posedge clk);
         #1;
         checks++;
         if (readData !== ZERO) begin
            failures++;
            $display("FAIL reset_write_ignored addr=%h got=%h want=%h", addrs[i], readData, ZERO);
         end
      end
      @(negedge clk);
      read_write = 1'b0;
      rst_n      = 1'b1;
   endtask

   task automatic test_write_read();
      do_write(10'h054, PAT_WR);
      address = 10'h050;
      #1;
      checks++;
      if (readData !== PAT_WR) begin
         failures++;
         $display("FAIL write_read_050 got=%h want=%h", readData, PAT_WR);
      end
      checks++;
      if (readData[31:0] !== 32'h00000000 || readData[127:96] !== 32'h33333333) begin
         failures++;
         $display("FAIL word_packing got=%h want=%h", readData, PAT_WR);
      end
      address = 10'h05C;
      #1;
      checks++;
      if (readData !== PAT_WR) begin
         failures++;
         $display("FAIL write_read_05C got=%h want=%h", readData, PAT_WR);
      end
   endtask

   task automatic test_block_isolation();
      do_write(10'h010, PAT_A);
      do_write(10'h020, PAT_5);
      address = 10'h010;
      #1;
      checks++;
      if (readData !== PAT_A) begin
         failures++;
         $display("FAIL iso_block1 got=%h want=%h", readData, PAT_A);
      end
      address = 10'h020;
      #1;
      checks++;
      if (readData !== PAT_5) begin
         failures++;
         $display("FAIL iso_block2 got=%h want=%h", readData, PAT_5);
      end
      address = 10'h000;
      #1;
      checks++;
      if (readData !== ZERO) begin
         failures++;
         $display("FAIL iso_block0 got=%h want=%h", readData, ZERO);
      end
   endtask

   task automatic test_back_to_back();
      // Same block on consecutive edges: the last write wins.
      do_write(10'h0A0, PAT_F);
      do_write(10'h0A8, PAT_C);
      address = 10'h0A4;
      #1;
      checks++;
      if (readData !== PAT_C) begin
         failures++;
         $display("FAIL b2b_last_wins got=%h want=%h", readData, PAT_C);
      end
   endtask

   task automatic test_read_only();
      @(negedge clk);
      address    = 10'h3F0;
      writeData  = PAT_F;
      read_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (readData !== ZERO) begin
            failures++;
            $display("FAIL read_only_edge%0d got=%h want=%h", i, readData, ZERO);
         end
      end
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      address    = 10'h100;
      writeData  = PAT_12;
      read_write = 1'b1;
      #1;
      checks++;
      if (readData !== ZERO) begin
         failures++;
         $display("FAIL same_cycle_before got=%h want=%h", readData, ZERO);
      end
      @(posedge clk);
      #1;
      read_write = 1'b0;
      checks++;
      if (readData !== PAT_12) begin
         failures++;
         $display("FAIL same_cycle_after got=%h want=%h", readData, PAT_12);
      end
   endtask

   task automatic test_async_reset();
      logic [9:0] addrs [5];
      addrs[0] = 10'h054; addrs[1] = 10'h010; addrs[2] = 10'h020;
      addrs[3] = 10'h0A0; addrs[4] = 10'h100;
      @(negedge clk);
      address = 10'h100;
      #1;
      // Pulse reset well before the next rising edge.
      rst_n = 1'b0;
      #1;
      checks++;
      if (readData !== ZERO) begin
         failures++;
         $display("FAIL async_clear got=%h want=%h", readData, ZERO);
      end
      for (int i = 0; i < 5; i++) begin
         address = addrs[i];
         #0.2;
         checks++;
         if (readData !== ZERO) begin
            failures++;
            $display("FAIL async_cleared addr=%h got=%h want=%h", addrs[i], readData, ZERO);
         end
      end
      rst_n = 1'b1;
      // First edge after reset release accepts a write.
      do_write(10'h200, PAT_C);
      #1;
      checks++;
      if (readData !== PAT_C) begin
         failures++;
         $display("FAIL post_reset_write got=%h want=%h", readData, PAT_C);
      end
      address = 10'h100;
      #1;
      checks++;
      if (readData !== ZERO) begin
         failures++;
         $display("FAIL post_reset_old_block got=%h want=%h", readData, ZERO);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      read_write = 1'b0;
      address    = 10'h000;
      writeData  = '0;
      test_reset();
      test_write_read();
      test_block_isolation();
      test_back_to_back();
      test_read_only();
      test_same_cycle();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
